// File: rtl/k2_result_uart_tx_if.sv
// Result-bus / UART-side signal bundle for k2_result_uart_tx.
// master = K2 processor side (drives result), slave = the UART output stage.
interface k2_result_uart_tx_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [7:0]                  result;
    logic                        tx;
    logic                        busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;

    modport master (output result, input tx, busy, fifo_count, overflow);
    modport slave  (input result, output tx, busy, fifo_count, overflow);
endinterface

// File: rtl/k2_result_uart_tx.sv
// Queues every change on the K2 result bus and serialises it as UART 8N1.
// Define K2_RESULT_HEX_EN to send each byte as two ASCII hex digits plus LF.
module k2_result_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input logic                clk,
    input logic                reset,
    k2_result_uart_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    prev_result_q;
    logic          prev_valid_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, push_acc, pop, full, tick;
    logic [7:0]    head;
`ifdef K2_RESULT_HEX_EN
    logic [1:0]    char_q, char_d;
    logic [7:0]    hold_q, hold_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction
`endif

    assign head = mem_q[rd_ptr_q];
    assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            prev_result_q <= '0;
            prev_valid_q  <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
`ifdef K2_RESULT_HEX_EN
            char_q        <= '0;
            hold_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            prev_result_q <= bus.result;
            prev_valid_q  <= 1'b1;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
`ifdef K2_RESULT_HEX_EN
            char_q        <= char_d;
            hold_q        <= hold_d;
`endif
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (reset && push_acc) mem_q[wr_ptr_q] <= bus.result;
    end

    // Change detector and FIFO bookkeeping.
    always_comb begin
        push       = !prev_valid_q || (bus.result != prev_result_q);
        full       = (count_q == (AW+1)'(FIFO_DEPTH));
        push_acc   = push && (!full || pop);
        wr_ptr_d   = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push_acc && !pop)      count_d = count_q + 1'b1;
        else if (!push_acc && pop) count_d = count_q - 1'b1;
        overflow_d = overflow_q | (push && !push_acc);
    end

    // TX next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef K2_RESULT_HEX_EN
        char_d  = char_q;
        hold_d  = hold_q;
`endif
        if (state_q != S_IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    cnt_d   = '0;
`ifdef K2_RESULT_HEX_EN
                    hold_d  = head;
                    char_d  = '0;
                    shift_d = hex_ascii(head[7:4]);
`else
                    shift_d = head;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
`ifdef K2_RESULT_HEX_EN
                    // Chain straight into the next character without an idle cycle.
                    if (char_q != 2'd2) begin
                        char_d  = char_q + 1'b1;
                        state_d = S_START;
                        shift_d = (char_q == 2'd0) ? hex_ascii(hold_q[3:0]) : 8'h0A;
                    end else begin
                        char_d  = '0;
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line driver.
    always_comb begin
        bus.busy = (state_q != S_IDLE);
        bus.tx   = 1'b1;
        if (state_q == S_START)     bus.tx = 1'b0;
        else if (state_q == S_DATA) bus.tx = shift_q[0];
    end

    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_k2_result_uart_tx.sv
// Directed bench for k2_result_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// A negedge UART monitor decodes frames into rx_q; the main sequence checks them.
module tb_k2_result_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    k2_result_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    k2_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         gap;
        int         busy;
        logic       bad;
    } rx_t;

    rx_t        rx_q[$];
    int         mon_cnt = 0;
    int         mon_gap = 0;
    int         mon_busy = 0;
    logic [7:0] mon_sh = '0;
    logic       mon_bad = 1'b0;

    // Frame sample points: start at +2, bit i at +6+4i, stop at +38 (mid-bit for CPB=4).
    always @(negedge clk) begin
        if (!reset) begin
            mon_cnt  <= 0;
            mon_gap  <= 0;
            mon_busy <= 0;
        end else if (mon_cnt == 0) begin
            if (bus.tx === 1'b0) begin
                mon_cnt  <= 1;
                mon_bad  <= 1'b0;
                mon_busy <= (bus.busy === 1'b1) ? 1 : 0;
            end else if (bus.busy === 1'b0) begin
                mon_gap <= mon_gap + 1;
            end
        end else begin
            mon_cnt  <= mon_cnt + 1;
            mon_busy <= mon_busy + ((bus.busy === 1'b1) ? 1 : 0);
            if (mon_cnt == 2 && bus.tx !== 1'b0) mon_bad <= 1'b1;
            if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
                mon_sh[(mon_cnt - 6) / 4] <= bus.tx;
            if (mon_cnt == 38 && bus.tx !== 1'b1) mon_bad <= 1'b1;
            if (mon_cnt == 39) begin
                rx_q.push_back('{mon_sh, mon_gap, mon_busy + ((bus.busy === 1'b1) ? 1 : 0), mon_bad});
                mon_cnt <= 0;
                mon_gap <= 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_rx(input string tag, input int budget, output rx_t e);
        int n = 0;
        while (rx_q.size() == 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_arrived"}, (rx_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (rx_q.size() != 0) e = rx_q.pop_front();
        else e = '{8'hxx, -1, -1, 1'b1};
    endtask

    initial begin
        rx_t e;
        int  peak;
        int  lows;

        bus.result = 8'h55;
        reset      = 1'b0;
        steps(3);
        chk("rst_tx", bus.tx, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_ovf", bus.overflow, 0);
        reset = 1'b1;
        step();
        chk("rel_count", bus.fifo_count, 1);

`ifdef K2_RESULT_HEX_EN
        bus.result = 8'h3C;
        get_rx("hex3c_hi", 100, e);
        chk("hex_55_hi", e.d, 8'h35);
        get_rx("hex55_lo", 100, e);
        chk("hex_55_lo", e.d, 8'h35);
        get_rx("hex55_lf", 100, e);
        chk("hex_55_lf", e.d, 8'h0A);
        steps(2);
        get_rx("hex3c_hi", 100, e);
        chk("hex_3c_hi", e.d, 8'h33);
        chk("hex_3c_hi_busy", e.busy, 40);
        get_rx("hex3c_lo", 100, e);
        chk("hex_3c_lo", e.d, 8'h43);
        chk("hex_3c_lo_gap", e.gap, 0);
        chk("hex_3c_lo_busy", e.busy, 40);
        get_rx("hex3c_lf", 100, e);
        chk("hex_3c_lf", e.d, 8'h0A);
        chk("hex_3c_lf_gap", e.gap, 0);
        chk("hex_3c_lf_busy", e.busy, 40);
        chk("hex_3c_frame", e.bad, 0);
        chk("hex_idle_after", bus.busy, 0);
        steps(3);
        bus.result = 8'hA5;
        get_rx("hexa5_hi", 100, e);
        chk("hex_a5_hi", e.d, 8'h41);
        get_rx("hexa5_lo", 100, e);
        chk("hex_a5_lo", e.d, 8'h35);
        chk("hex_a5_lo_gap", e.gap, 0);
        get_rx("hexa5_lf", 100, e);
        chk("hex_a5_lf", e.d, 8'h0A);
`else
        get_rx("first55", 100, e);
        chk("first_55", e.d, 8'h55);
        chk("first_55_busy", e.busy, 40);
        chk("first_55_frame", e.bad, 0);
        steps(4);

        // Single change: tx falls two edges after the new value appears.
        bus.result = 8'h00;
        get_rx("zero", 100, e);
        chk("zero_data", e.d, 8'h00);
        steps(4);
        bus.result = 8'hA5;
        step();
        chk("chg_k1_tx", bus.tx, 1);
        chk("chg_k1_count", bus.fifo_count, 1);
        step();
        chk("chg_k2_tx", bus.tx, 0);
        chk("chg_k2_busy", bus.busy, 1);
        get_rx("a5", 100, e);
        chk("a5_data", e.d, 8'hA5);
        chk("a5_busy", e.busy, 40);
        chk("a5_frame", e.bad, 0);
        chk("a5_idle_after", bus.busy, 0);
        steps(4);

        // Burst of ten distinct values: eight fit after the first pop, 0x0A is dropped.
        peak = 0;
        for (int v = 1; v <= 10; v++) begin
            bus.result = v[7:0];
            step();
            if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
        end
        chk("burst_peak", peak, 8);
        chk("burst_full", bus.fifo_count, 8);
        chk("burst_ovf", bus.overflow, 1);
        for (int i = 1; i <= 9; i++) begin
            get_rx($sformatf("burst%0d", i), 100, e);
            chk($sformatf("burst%0d_data", i), e.d, i);
            chk($sformatf("burst%0d_frame", i), e.bad, 0);
            if (i > 1) chk($sformatf("burst%0d_gap", i), e.gap, 1);
        end
        steps(100);
        chk("burst_no_0a", rx_q.size(), 0);
        chk("burst_drained", bus.fifo_count, 0);
        chk("burst_ovf_sticky", bus.overflow, 1);

        // Steady value: one frame, then silence.
        bus.result = 8'h33;
        get_rx("h33", 100, e);
        chk("h33_data", e.d, 8'h33);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.tx !== 1'b1) lows++;
        end
        chk("steady_no_start", lows, 0);
        chk("steady_rx_none", rx_q.size(), 0);
        chk("steady_count", bus.fifo_count, 0);

        // Reset during DATA bit 3 of 0x44 with four more entries queued.
        for (int v = 8'h44; v <= 8'h48; v++) begin
            bus.result = v[7:0];
            step();
        end
        chk("mid_count", bus.fifo_count, 4);
        steps(13);
        chk("mid_bit3", bus.tx, 0);
        chk("mid_busy", bus.busy, 1);
        chk("mid_ovf_pre", bus.overflow, 1);
        reset      = 1'b0;
        bus.result = 8'h77;
        step();
        chk("mid_rst_tx", bus.tx, 1);
        chk("mid_rst_count", bus.fifo_count, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ovf", bus.overflow, 0);
        reset = 1'b1;
        step();
        chk("mid_rel_count", bus.fifo_count, 1);
        get_rx("h77", 100, e);
        chk("h77_data", e.d, 8'h77);
        chk("h77_frame", e.bad, 0);
        steps(60);
        chk("mid_only_one", rx_q.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/k2_result_uart_tx.md
# k2_result_uart_tx

Downstream output stage for `K2_process`. It watches the processor's 8-bit `result` bus and queues every new value in a small FIFO. It serialises the queued values onto a single UART 8N1 line so program output can be observed on a board pin or terminal. The block consumes `result` directly and needs no handshake from the processor.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, 8: queue entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `result`  in  8  K2 result bus, sampled every cycle.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high while any frame (or character sequence) is in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
- `overflow`  out  1  sticky: a value was dropped because the FIFO was full.

## Operation
- **Change detector:** registers `prev_result` and `prev_valid`.
  - Push request = `!prev_valid || result != prev_result`.
  - `prev_result` updates every non-reset cycle. `prev_valid` goes to 1 on the first cycle after reset release.
  - Consequence: the first sampled value after reset is always queued.
- **FIFO:** circular buffer with read/write pointers.
  - A push is accepted if not full, or if a pop occurs in the same cycle. The count is then unchanged.
  - A push while full with no pop: the value is dropped and `overflow` is set to 1. `overflow` stays set until reset.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `fifo_count`>0, pop the head into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. A 3-bit bit index counts 0..7.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then IDLE (raw mode).
- **Bit timer:** counts 0..`CLKS_PER_BIT`-1 and reloads on every state/bit advance.
- `busy` = (state != IDLE).
- **Reset outputs:** `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0. FSM goes to IDLE, pointers to 0, `prev_valid`=0.

## Timing
- A `result` value that is new at edge k is compared and written at edge k+1, so `fifo_count` increments after k+1.
- Edge k+2: IDLE pops and enters START. `tx` falls after k+2.
- Raw frame occupies exactly 10·`CLKS_PER_BIT` cycles with `busy`=1.
- There is exactly one IDLE cycle (`busy`=0) between consecutive FIFO entries.
- Reset asserted mid-frame: at the next edge `tx` returns to 1 and the frame is truncated. The FIFO is emptied and `overflow` is cleared. No partial frame resumes.
- `result` changing every cycle: each distinct cycle value is a separate push. Values that revert (A→B→A) are pushed three times.

## Configuration
- `K2_RESULT_HEX_EN` defined: each popped byte is sent as three frames.
  - Frame 1: ASCII upper-case hex of the high nibble ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
  - Frame 2: ASCII hex of the low nibble.
  - Frame 3: 0x0A.
  - A 2-bit character index sequences the frames. STOP goes directly to START between characters, so `busy` stays 1 for 30·`CLKS_PER_BIT` cycles per byte.
- Macro undefined: raw mode, one binary frame per byte. No character-index logic is present.

## Test plan
All tests use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.
- **Reset:** hold `reset`=0 for 3 cycles with `result`=0x55 → `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0. After release, `fifo_count`=1 one cycle later, then a 0x55 frame is sent.
- **Single change:** `result` 0x00 steady and sent, then 0xA5 → `tx` falls 2 cycles after the change. Bits 1,0,1,0,0,1,0,1 are sent, 4 cycles each, then stop. `busy` high 40 cycles.
- **Burst overflow:** from idle and empty, `result` = 0x01..0x0A on consecutive cycles → `fifo_count` peaks at 8, 0x0A is dropped, `overflow`=1. The line carries 0x01..0x09 in order, each followed by one idle cycle.
- **No change:** `result` held 0x33 for 200 cycles after its frame → no further start bits, `tx`=1, `fifo_count`=0.
- **Reset mid-frame:** assert `reset` during DATA bit 3 with 4 entries queued → `tx`=1 and `fifo_count`=0 at the next edge. After release, only the current `result` is sent.
- **Hex mode (`K2_RESULT_HEX_EN`):** `result`=0x3C → frames 0x33, 0x43, 0x0A, with `busy` continuously high for 120 cycles.
